// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-control bundle between hazard/decode logic, the PC register and the sequencer.
interface pc_fetch_sequencer_if;
  logic [31:0] iPC;
  logic        iStall;
  logic        iRedirect;
  logic [31:0] iRedirectTarget;
  logic        iBrValid;
  logic [31:0] iBrPC;
  logic        iBrTaken;
  logic [31:0] iBrTarget;
  logic        iHalt;
  logic        iResume;
  logic        oPCWrite;
  logic        oCache;
  logic [31:0] oAddress;
  logic [31:0] oCacheAddress;
  logic        oFlush;
  logic [1:0]  oState;

  modport master (
    output iPC, iStall, iRedirect, iRedirectTarget, iBrValid, iBrPC, iBrTaken,
           iBrTarget, iHalt, iResume,
    input  oPCWrite, oCache, oAddress, oCacheAddress, oFlush, oState
  );

  modport slave (
    input  iPC, iStall, iRedirect, iRedirectTarget, iBrValid, iBrPC, iBrTaken,
           iBrTarget, iHalt, iResume,
    output oPCWrite, oCache, oAddress, oCacheAddress, oFlush, oState
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: picks PC+4, redirect or BTB prediction; BTB built only with PC_SEQ_BTB_EN.
// Zero-cycle decision (outputs combinational from state/inputs); stall/halt hold the PC.
module pc_fetch_sequencer #(
  parameter int BTB_ENTRIES = 4,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input logic                  Clk,
  input logic                  Reset,
  pc_fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        btb_hit;
  logic [31:0] btb_tgt;
  logic        pc_write, cache_sel, flush;
  logic [31:0] next_addr;

`ifdef PC_SEQ_BTB_EN
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [IDX_W-1:0]       rd_idx, wr_idx;
  logic [TAG_W-1:0]       rd_tag, wr_tag;
  logic                   wr_match;
  logic                   unused_lsb;

  assign rd_idx = bus.iPC[IDX_W+1:2];
  assign rd_tag = bus.iPC[31:IDX_W+2];
  assign wr_idx = bus.iBrPC[IDX_W+1:2];
  assign wr_tag = bus.iBrPC[31:IDX_W+2];
  assign unused_lsb = ^bus.iBrPC[1:0];

  // Lookup reads the current array contents, so an update this cycle is seen next cycle.
  assign btb_hit  = btb_vld[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign btb_tgt  = btb_hit ? btb_tgt_q[rd_idx] : 32'd0;
  assign wr_match = btb_vld[wr_idx] && (btb_tag[wr_idx] == wr_tag);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      btb_vld <= '0;
    end else if (bus.iBrValid) begin
      if (bus.iBrTaken) begin
        btb_vld[wr_idx] <= 1'b1;
      end else if (wr_match) begin
        btb_vld[wr_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && bus.iBrValid && bus.iBrTaken) begin
      btb_tag[wr_idx]   <= wr_tag;
      btb_tgt_q[wr_idx] <= bus.iBrTarget;
    end
  end
`else
  logic unused_br;

  assign unused_br = ^{bus.iBrValid, bus.iBrPC, bus.iBrTaken, bus.iBrTarget};
  assign btb_hit   = 1'b0;
  assign btb_tgt   = 32'd0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    cache_sel = 1'b0;
    flush     = 1'b0;
    next_addr = bus.iPC + 32'd4;
    unique case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (bus.iRedirect) begin
          pc_write  = 1'b1;
          flush     = 1'b1;
          next_addr = bus.iRedirectTarget;
        end else if (bus.iHalt) begin
          state_nxt = HALT;
        end else if (!bus.iStall) begin
          pc_write  = 1'b1;
          cache_sel = btb_hit;
        end
      end
      HALT: begin
        if (bus.iResume) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset only gates the control strobes; the address outputs keep their usual meaning.
    if (Reset) begin
      pc_write  = 1'b0;
      cache_sel = 1'b0;
      flush     = 1'b0;
    end
  end

  assign bus.oPCWrite      = pc_write;
  assign bus.oCache        = cache_sel;
  assign bus.oAddress      = next_addr;
  assign bus.oCacheAddress = btb_tgt;
  assign bus.oFlush        = flush;
  assign bus.oState        = state;

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Controller for the program counter register. It decides each cycle whether the PC updates and where the next fetch address comes from: sequential PC+4, a resolved branch redirect, or a prediction from a small internal branch target buffer (BTB). Its outputs drive the PC register's write-enable, cache-select, address and cache-address inputs directly. It receives stall and redirect requests from the hazard/execute logic, and halt/resume from decode.

## Interface
- `BTB_ENTRIES`, 4: number of BTB entries; must be a power of two, at least 2.
- `IDX_W`, log2(BTB_ENTRIES): derived BTB index width.
- `Clk` in 1: clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `iPC` in 32: current PC value, fed back from the PC register output.
- `iStall` in 1: hazard stall; hold the PC.
- `iRedirect` in 1: execute-stage redirect request.
- `iRedirectTarget` in 32: redirect destination.
- `iBrValid` in 1: a branch resolved this cycle (BTB update strobe).
- `iBrPC` in 32: PC of the resolved branch.
- `iBrTaken` in 1: actual outcome of the resolved branch.
- `iBrTarget` in 32: actual target of the resolved branch.
- `iHalt` in 1: halt decoded.
- `iResume` in 1: leave the halt state.
- `oPCWrite` out 1: drives the PC register's write-enable.
- `oCache` out 1: selects the cache address at the PC register.
- `oAddress` out 32: non-predicted next PC.
- `oCacheAddress` out 32: BTB-predicted next PC.
- `oFlush` out 1: squash the IF/ID stages this cycle.
- `oState` out 2: current state; IDLE=0, RUN=1, HALT=2.

## Operation
- **State machine.** State is registered. All other outputs are combinational from state and inputs, so the PC updates on the same edge the decision is made.
- **Reset.** Synchronous reset forces state to IDLE and clears all BTB valid bits.
  - While `Reset` is high: `oPCWrite`=0, `oCache`=0, `oFlush`=0.
  - While `Reset` is high, `oAddress` and `oCacheAddress` still follow their normal combinational definitions.
- **IDLE.** All control outputs 0. Moves to RUN on the next edge unconditionally.
- **RUN.** Priority, highest first:
  1. `iRedirect`: `oPCWrite`=1, `oCache`=0, `oAddress`=`iRedirectTarget`, `oFlush`=1. Overrides `iStall`, `iHalt` and any BTB hit. State stays RUN.
  2. `iHalt`: `oPCWrite`=0. State goes to HALT next edge.
  3. `iStall`: `oPCWrite`=0, `oCache`=0.
  4. BTB hit on `iPC`: `oPCWrite`=1, `oCache`=1.
  5. Otherwise: `oPCWrite`=1, `oCache`=0.
- **Address outputs.**
  - `oAddress` = `iPC`+4, 32-bit, wrapping modulo 2^32 (0xFFFFFFFC → 0x0), except during a redirect (see above).
  - `oCacheAddress` = target field of the hit entry; 0 on a miss.
- **HALT.** `oPCWrite`=0, `oCache`=0, `oFlush`=0; `iRedirect` and `iStall` are ignored. `iResume` moves state to RUN next edge.
- **BTB.** Direct-mapped, `BTB_ENTRIES` entries. Each entry holds a valid bit, a tag (bits 31 down to 2+IDX_W) and a 32-bit target.
  - Index = PC bits [IDX_W+1:2].
  - Hit = entry valid and tag equal to the tag bits of `iPC`.
- **BTB update.** Applied on the edge when `iBrValid`=1 (not in reset), in any state:
  - Taken branch: write valid=1, the tag from `iBrPC`, and `iBrTarget`.
  - Not-taken branch whose tag matches the valid entry: clear valid.
  - Not-taken branch with no tag match: no change.
- **Read-before-write.** A same-cycle lookup at the index being updated sees the old contents.

## Timing
- Decision latency is zero cycles: the PC register captures `oAddress` or `oCacheAddress` on the same edge.
- First PC increment is one cycle after reset deasserts, because IDLE lasts exactly one cycle.
- `oFlush` is a single-cycle pulse per cycle of `iRedirect` in RUN.
- A BTB update is visible to lookups from the following cycle.
- `Reset` asserted in any state takes effect at the next edge, overriding `iResume`, `iRedirect` and `iBrValid`.

## Configuration
- `PC_SEQ_BTB_EN` defined: the BTB is built, and prediction behaves as described above.
- `PC_SEQ_BTB_EN` undefined: no BTB storage is built.
  - `oCache` is constant 0 and `oCacheAddress` is constant 0.
  - The `iBr*` inputs are ignored.
  - RUN priority reduces to redirect > halt > stall > sequential.

## Test plan
All scenarios use `PC_SEQ_BTB_EN` defined, `BTB_ENTRIES`=4, and the PC register in the loop.
- **Reset and sequential fetch.** Reset held 2 cycles → `oState`=IDLE for 1 cycle with `oPCWrite`=0 → PC sequence 0x0, 0x4, 0x8, 0xC.
- **Stall.** `iStall` for 2 cycles at PC=0x8 → `oPCWrite`=0 and PC holds 0x8 → then PC advances to 0xC.
- **Redirect beats stall.** `iRedirect`+`iStall` with target 0x40 → `oPCWrite`=1, `oAddress`=0x40, `oFlush`=1 → PC=0x40 next cycle.
- **BTB hit, invalidate, alias.**
  - Taken update: `iBrPC`=0x10, `iBrTarget`=0x80. Later `iPC`=0x10 → `oCache`=1, `oCacheAddress`=0x80.
  - Not-taken update for 0x10, then `iPC`=0x10 → `oCache`=0, `oAddress`=0x14.
  - Alias: with 0x10 valid again, `iPC`=0x20 (same index, different tag) → miss.
- **Halt and resume.** `iHalt` at PC=0x18 → HALT, PC frozen at 0x18. `iRedirect` to 0x40 while halted → ignored. `iResume` → RUN, then PC=0x1C.
- **Reset while halted.** `Reset` in HALT with a valid BTB entry → IDLE next cycle. `iPC` at that entry's address then misses.
